simplified_sha256: RTL and testbench

- SHA-256 co-processor.
- Reads a NUM_OF_WORDS x 32-bit message from a shared single-port word memory and applies standard SHA-256 padding internally.
- Hashes all 512-bit blocks, then writes the 8-word digest H0..H7 back to the same memory.
- Sits beside the system memory and is driven by a simple start/done handshake.

---
 rtl/sha256_pkg.sv | 65 ++++++
 rtl/sha256_round.sv | 13 +
 rtl/simplified_sha256.sv | 222 ++++++++++++++++++++++
 tb/tb_simplified_sha256.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash values, FSM
// encoding and the round / message-schedule functions.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    BLOCK   = 3'd2,
    COMPUTE = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Element 0 is a (or H0), element 7 is h (or H7).
  typedef logic [7:0][31:0] words8_t;

  localparam words8_t IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] sch_s0(input logic [31:0] x);
    return ror(x, 5'd7) ^ ror(x, 5'd18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sch_s1(input logic [31:0] x);
    return ror(x, 5'd17) ^ ror(x, 5'd19) ^ (x >> 10);
  endfunction

  function automatic words8_t round(input words8_t s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] big_s1, ch, t1, big_s0, maj, t2;
    words8_t r;
    big_s1 = ror(s[4], 5'd6) ^ ror(s[4], 5'd11) ^ ror(s[4], 5'd25);
    ch     = (s[4] & s[5]) ^ (~s[4] & s[6]);
    t1     = s[7] + big_s1 + ch + k + w;
    big_s0 = ror(s[0], 5'd2) ^ ror(s[0], 5'd13) ^ ror(s[0], 5'd22);
    maj    = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
    t2     = big_s0 + maj;
    r[0] = t1 + t2;
    r[1] = s[0];
    r[2] = s[1];
    r[3] = s[2];
    r[4] = s[3] + t1;
    r[5] = s[4];
    r[6] = s[5];
    r[7] = s[6];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: a..h, W[t], K[t] -> next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  words8_t     state_i,
  input  logic [31:0] w_i,
  input  logic [31:0] k_i,
  output words8_t     state_o
);

  assign state_o = round(state_i, k_i, w_i);

endmodule

// File: rtl/simplified_sha256.sv
// SHA-256 co-processor: reads a message from shared memory, pads and hashes it,
// writes H0..H7 back. Define SIMPLIFIED_SHA256_ROLLING_W_EN for a 16-word W window.
module simplified_sha256
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int NUM_BLOCKS = (NUM_OF_WORDS * 32 + 65 + 511) / 512;
  localparam int BW         = (NUM_OF_WORDS > 1) ? $clog2(NUM_OF_WORDS) : 1;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [2:0]  blk_q, blk_d;
  logic [15:0] maddr_q, maddr_d, oaddr_q, oaddr_d;
  logic        done_q, done_d, we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] buf_q [NUM_OF_WORDS];
  words8_t     h_q, v_q, round_s;
  logic [31:0] pad_s [16];
  logic [31:0] wt_s, new_w_s;
  logic [BW-1:0] rd_idx_s;

  assign mem_clk        = clk;
  assign done           = done_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign rd_idx_s       = BW'(cnt_q - 7'd1);

  // Control and memory-port registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 7'd0;
      blk_q   <= 3'd0;
      maddr_q <= 16'd0;
      oaddr_q <= 16'd0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      maddr_q <= maddr_d;
      oaddr_q <= oaddr_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Memory outputs are registered, so they are computed for the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    maddr_d = maddr_q;
    oaddr_d = oaddr_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          cnt_d   = 7'd0;
          blk_d   = 3'd0;
          maddr_d = message_addr;
          oaddr_d = output_addr;
          addr_d  = message_addr;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (cnt_q == 7'(NUM_OF_WORDS)) begin
          state_d = BLOCK;
        end else begin
          cnt_d = cnt_q + 7'd1;
          if ((cnt_q + 7'd1) < 7'(NUM_OF_WORDS)) begin
            addr_d = maddr_q + 16'(cnt_q) + 16'd1;
          end else begin
            addr_d = addr_q;
          end
        end
      end
      BLOCK: begin
        state_d = COMPUTE;
        cnt_d   = 7'd0;
      end
      COMPUTE: begin
        if (cnt_q == 7'd64) begin
          if (blk_q == 3'(NUM_BLOCKS - 1)) begin
            state_d = WRITE;
            cnt_d   = 7'd0;
            we_d    = 1'b1;
            addr_d  = oaddr_q;
            wdata_d = h_q[0] + v_q[0];
          end else begin
            state_d = BLOCK;
            blk_d   = blk_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      WRITE: begin
        if (cnt_q == 7'd7) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 7'd1;
          we_d    = 1'b1;
          addr_d  = oaddr_q + 16'(cnt_q) + 16'd1;
          wdata_d = h_q[cnt_q[2:0] + 3'd1];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Padded view of the current block; memory words are used verbatim
  always_comb begin
    int g;
    g = 0;
    pad_s = '{default: 32'h0};
    for (int i = 0; i < 16; i++) begin
      g = int'(blk_q) * 16 + i;
      if (g < NUM_OF_WORDS) begin
        pad_s[i] = buf_q[BW'(g)];
      end else if (g == NUM_OF_WORDS) begin
        pad_s[i] = 32'h8000_0000;
      end else if (g == NUM_BLOCKS * 16 - 1) begin
        pad_s[i] = 32'(NUM_OF_WORDS * 32);
      end else begin
        pad_s[i] = 32'h0;
      end
    end
  end

  // Message buffer, hash state and working variables
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: if (start) h_q <= IV;
      READ: if (cnt_q != 7'd0) buf_q[rd_idx_s] <= mem_read_data;
      BLOCK: v_q <= h_q;
      COMPUTE: begin
        if (cnt_q == 7'd64) begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
        end else begin
          v_q <= round_s;
        end
      end
      default: ;
    endcase
  end

`ifdef SIMPLIFIED_SHA256_ROLLING_W_EN
  logic [31:0] w_q [16];

  assign wt_s    = w_q[0];
  assign new_w_s = w_q[0] + sch_s0(w_q[1]) + w_q[9] + sch_s1(w_q[14]);

  // Window holds W[t..t+15]; each round appends W[t+16]
  always_ff @(posedge clk) begin
    if (state_q == BLOCK) begin
      for (int i = 0; i < 16; i++) w_q[i] <= pad_s[i];
    end else if (state_q == COMPUTE && cnt_q != 7'd64) begin
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
      w_q[15] <= new_w_s;
    end
  end
`else
  logic [31:0] w_q [64];
  logic [5:0]  t_s;

  assign t_s     = cnt_q[5:0];
  assign wt_s    = w_q[t_s];
  assign new_w_s = w_q[t_s] + sch_s0(w_q[t_s + 6'd1]) + w_q[t_s + 6'd9] + sch_s1(w_q[t_s + 6'd14]);

  // Full schedule array; W[t+16] is produced while round t runs
  always_ff @(posedge clk) begin
    if (state_q == BLOCK) begin
      for (int i = 0; i < 16; i++) w_q[i] <= pad_s[i];
    end else if (state_q == COMPUTE && cnt_q < 7'd48) begin
      w_q[t_s + 6'd16] <= new_w_s;
    end
  end
`endif

  sha256_round u_round (
    .state_i (v_q),
    .w_i     (wt_s),
    .k_i     (K[cnt_q[5:0]]),
    .state_o (round_s)
  );

endmodule

// File: tb/tb_simplified_sha256.sv
// Self-checking bench: shared memory model, two DUT instances (20 and 13 words),
// and a behavioural SHA-256 reference.
module tb_simplified_sha256;

  typedef logic [7:0][31:0] dig_t;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic        clk = 1'b0, reset = 1'b0;
  logic        start20 = 1'b0, start13 = 1'b0, sel13 = 1'b0;
  logic [15:0] maddr = 16'd0, oaddr = 16'd0;
  logic        done20, mclk20, we20, done13, mclk13, we13;
  logic [15:0] addr20, addr13;
  logic [31:0] wd20, wd13, rdata;
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = 16'd0;
  logic [31:0] ld_data = 32'd0;
  logic [31:0] mem [0:65535];
  logic        m_we;
  logic [15:0] m_addr;
  logic [31:0] m_wd;
  int wr_cnt = 0, bad_cnt = 0, done_cnt = 0;
  int n_assert = 0, n_fail = 0;

  simplified_sha256 #(.NUM_OF_WORDS(20)) dut (
    .clk(clk), .reset(reset), .start(start20), .message_addr(maddr), .output_addr(oaddr),
    .done(done20), .mem_clk(mclk20), .mem_we(we20), .mem_addr(addr20),
    .mem_write_data(wd20), .mem_read_data(rdata));

  simplified_sha256 #(.NUM_OF_WORDS(13)) dut13 (
    .clk(clk), .reset(reset), .start(start13), .message_addr(maddr), .output_addr(oaddr),
    .done(done13), .mem_clk(mclk13), .mem_we(we13), .mem_addr(addr13),
    .mem_write_data(wd13), .mem_read_data(rdata));

  always #5 clk = ~clk;

  assign m_we   = sel13 ? we13 : we20;
  assign m_addr = sel13 ? addr13 : addr20;
  assign m_wd   = sel13 ? wd13 : wd20;

  always @(posedge mclk20) begin
    if (m_we) mem[m_addr] <= m_wd;
    else if (ld_en) mem[ld_addr] <= ld_data;
    rdata <= mem[m_addr];
  end

  always @(posedge clk) begin
    if (m_we) begin
      wr_cnt <= wr_cnt + 1;
      if (m_addr < oaddr || m_addr > oaddr + 16'd7) bad_cnt <= bad_cnt + 1;
    end
    if (done20 | done13) done_cnt <= done_cnt + 1;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 over a word queue
  function automatic dig_t sha_ref(input logic [31:0] m[$]);
    logic [31:0] p[$];
    logic [31:0] w[64];
    logic [31:0] hv[8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    dig_t r;
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    p = m;
    p.push_back(32'h8000_0000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    p.push_back(32'h0);
    p.push_back(32'(m.size() * 32));
    for (int blk = 0; blk < p.size() / 16; blk++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) w[t] = p[blk * 16 + t];
        else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                  + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      end
      a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
      hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    end
    for (int n = 0; n < 8; n++) r[n] = hv[n];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] m[$], input logic [15:0] ma, input logic [15:0] oa);
    for (int i = 0; i < m.size(); i++) begin
      @(negedge clk); ld_en = 1'b1; ld_addr = ma + 16'(i); ld_data = m[i];
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk); ld_en = 1'b1; ld_addr = oa + 16'(n); ld_data = 32'hdead_0000 | 32'(n);
    end
    @(negedge clk); ld_en = 1'b0;
  endtask

  task automatic set_start(input bit use13, input logic v);
    if (use13) start13 = v; else start20 = v;
  endtask

  task automatic run(input string tag, input bit use13, input logic [31:0] m[$],
                     input logic [15:0] ma, input logic [15:0] oa, input int exp_lat, input int restart_at);
    int lat, wr0, bad0, d0;
    bit seen;
    dig_t dg;
    load(m, ma, oa);
    sel13 = use13; maddr = ma; oaddr = oa;
    wr0 = wr_cnt; bad0 = bad_cnt; d0 = done_cnt;
    set_start(use13, 1'b1);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 600) begin
      @(negedge clk);
      lat++;
      set_start(use13, restart_at > 0 && lat >= restart_at && lat < restart_at + 5);
      if (use13 ? done13 : done20) seen = 1'b1;
    end
    set_start(use13, 1'b0);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    repeat (4) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_writes"}, 32'(wr_cnt - wr0), 32'd8);
    chk({tag, "_stray_writes"}, 32'(bad_cnt - bad0), 32'd0);
    dg = sha_ref(m);
    for (int n = 0; n < 8; n++) chk($sformatf("%s_H%0d", tag, n), mem[oa + 16'(n)], dg[n]);
  endtask

  initial begin
    logic [31:0] msg[$];
    logic [15:0] ma, oa;
    int wr0;

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done20), 32'd0);
    chk("rst_we", 32'(we20), 32'd0);
    chk("rst_addr", 32'(addr20), 32'd0);
    chk("rst_wdata", wd20, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    msg = {};
    msg.push_back(32'h0123_4567);
    for (int i = 1; i < 19; i++) msg.push_back({msg[i-1][30:0], msg[i-1][31]});
    msg.push_back(32'h0);
    run("seed", 1'b0, msg, 16'd0, 16'd1000, 162, 0);

    msg = {};
    for (int i = 0; i < 20; i++) msg.push_back(32'h0);
    run("zero", 1'b0, msg, 16'd0, 16'd1000, 162, 0);

    msg = {};
    for (int i = 0; i < 20; i++) msg.push_back($urandom);
    ma = 16'($urandom_range(0, 20000));
    oa = ma + 16'd64 + 16'($urandom_range(0, 3000));
    run("rand", 1'b0, msg, ma, oa, 162, 0);

    msg = {};
    for (int i = 0; i < 20; i++) msg.push_back($urandom);
    load(msg, 16'd0, 16'd1000);
    sel13 = 1'b0; maddr = 16'd0; oaddr = 16'd1000;
    wr0 = wr_cnt;
    start20 = 1'b1;
    @(negedge clk);
    start20 = 1'b0;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_done", 32'(done20), 32'd0);
    chk("abort_we", 32'(we20), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_no_writes", 32'(wr_cnt - wr0), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run("after_abort", 1'b0, msg, 16'd0, 16'd1000, 162, 0);

    msg = {};
    for (int i = 0; i < 20; i++) msg.push_back($urandom);
    run("restart_ignored", 1'b0, msg, 16'd40, 16'd2000, 162, 60);

    msg = {};
    for (int i = 0; i < 13; i++) msg.push_back($urandom);
    run("n13", 1'b1, msg, 16'd300, 16'd1000, 89, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
